// File: rtl/fetch_buffer.sv
// Instruction fetch front end: issues in-order fetches under a credit limit and
// buffers returned instructions for decode, squashing stale responses on redirect.
module fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pcbranch,
  input  logic            stallD,
  output logic            validD,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]   count, outstanding, drop;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [CW:0] inflight;
  logic        accept, resp_drop, push, pop;

  // Credit covers both buffered and in-flight instructions, so a push can never overflow.
  always_comb begin
    inflight  = {1'b0, count} + {1'b0, outstanding};
    imem_req  = !rst && !pcsrc && (inflight < {1'b0, FULL});
    imem_addr = fetch_pc;
    accept    = imem_req && imem_gnt;
    resp_drop = imem_rvalid && (pcsrc || (drop != '0));
    push      = imem_rvalid && !resp_drop;
    validD    = !rst && (count != '0);
    pop       = validD && !stallD && !pcsrc;
    instrD    = instr_mem[rd_ptr];
    pcD       = pc_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (pcsrc) begin
        // Everything still in flight now belongs to the abandoned path.
        fetch_pc <= pcbranch;
        resp_pc  <= pcbranch;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop     <= outstanding - CW'(imem_rvalid);
      end else begin
        if (accept)    fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_drop) drop     <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && (count == FULL)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: epoch-tagged transaction model of the
// fetch stream, an in-order memory model, directed scenarios and random traffic.
module tb_fetch_buffer;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, pcsrc, stallD, validD;
  logic [31:0] imem_addr, imem_rdata, pcbranch, instrD, pcD;

  always #5 clk = ~clk;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcsrc(pcsrc), .pcbranch(pcbranch), .stallD(stallD),
    .validD(validD), .instrD(instrD), .pcD(pcD)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];
  ent_t        buf_q[$];
  logic [31:0] acc_log[$];
  int          epoch = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  logic [31:0] m_fetch = RESET_PC;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic st, input logic ps,
                      input logic [31:0] pb, input logic g);
    logic m_req, m_valid, resp, pop;
    req_t q;
    int   due;
    @(negedge clk);
    rst = r; stallD = st; pcsrc = ps; pcbranch = pb; imem_gnt = g;
    resp = !r && (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rvalid = resp;
    imem_rdata  = resp ? word_at(pend[0].addr) : $urandom;
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = validD;
    obs_pc = pcD; obs_instr = instrD;
    m_req   = !r && !ps && (buf_q.size() + pend.size() < DEPTH);
    m_valid = !r && (buf_q.size() != 0);
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_fetch);
    chk("validD", validD, m_valid);
    if (m_valid) begin
      chk("pcD", pcD, buf_q[0].pc);
      chk("instrD", instrD, buf_q[0].instr);
    end
    if (r) begin
      pend.delete(); buf_q.delete(); epoch++; m_fetch = RESET_PC;
    end else begin
      pop = m_valid && !st && !ps;
      if (pop) void'(buf_q.pop_front());
      if (resp) begin
        q = pend.pop_front();
        if (!ps && q.epoch == epoch) buf_q.push_back('{pc: q.addr, instr: word_at(q.addr)});
      end
      if (ps) begin
        buf_q.delete(); epoch++; m_fetch = pb;
      end
      if (m_req && g) m_fetch = m_fetch + 32'd4;
      if (imem_req && g) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: imem_addr, epoch: epoch, due: due});
        acc_log.push_back(imem_addr);
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    acc_log.delete();
  endtask

  // Runs until decode sees an instruction; an exhausted budget counts as a failure.
  task automatic first_valid(input string name, input logic [31:0] exp_pc, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        seen = 1;
        chk(name, obs_pc, exp_pc);
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; pcsrc = 1'b0; pcbranch = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;

    // Streaming with single-cycle memory.
    do_reset(3);
    step(0, 0, 0, 0, 1);
    chk("s1_req0", obs_req, 1'b1); chk("s1_addr0", obs_addr, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("s1_addr1", obs_addr, 32'h4); chk("s1_valid_c1", obs_valid, 1'b0);
    step(0, 0, 0, 0, 1);
    chk("s1_valid_c2", obs_valid, 1'b1); chk("s1_pc0", obs_pc, 32'h0);
    chk("s1_instr0", obs_instr, word_at(32'h0));
    step(0, 0, 0, 0, 1); chk("s1_pc1", obs_pc, 32'h4);
    step(0, 0, 0, 0, 1); chk("s1_pc2", obs_pc, 32'h8);

    // Decode stalled long enough to fill the buffer.
    do_reset(2);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1);
    chk("s2_accepts", acc_log.size(), 32'd4);
    chk("s2_req_low", obs_req, 1'b0); chk("s2_full_valid", obs_valid, 1'b1);
    step(0, 0, 0, 0, 1); chk("s2_pc0", obs_pc, 32'h0); chk("s2_req_held", obs_req, 1'b0);
    step(0, 0, 0, 0, 1); chk("s2_pc4", obs_pc, 32'h4);
    chk("s2_resume", obs_req, 1'b1); chk("s2_resume_addr", obs_addr, 32'h10);
    step(0, 0, 0, 0, 1); chk("s2_pc8", obs_pc, 32'h8);
    step(0, 0, 0, 0, 1); chk("s2_pc12", obs_pc, 32'hC);

    // Redirect with three fetches in flight at 3-cycle latency.
    do_reset(2);
    lat_min = 3; lat_max = 3;
    step(0, 0, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("s3_addrs", {acc_log[0][7:0], acc_log[1][7:0], acc_log[2][7:0]}, 32'h0020_2428);
    step(0, 0, 1, 32'h100, 1);
    chk("s3_valid_low", obs_valid, 1'b0);
    step(0, 0, 0, 0, 1);
    chk("s3_next_req", obs_req, 1'b1); chk("s3_next_addr", obs_addr, 32'h100);
    first_valid("s3_first_pc", 32'h100, 20);

    // Redirect coinciding with a response and a pop.
    do_reset(2);
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h400, 1);
    chk("s4_valid_at_redirect", obs_valid, 1'b1);
    first_valid("s4_first_pc", 32'h400, 20);

    // Grant withheld: address held, nothing issued.
    do_reset(2);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("s5_req", obs_req, 1'b1); chk("s5_addr_hold", obs_addr, 32'h0);
    end
    chk("s5_none_accepted", acc_log.size(), 32'd0);
    first_valid("s5_first_pc", 32'h0, 10);

    // Address wrap, then reset with requests in flight.
    step(0, 0, 1, 32'hFFFF_FFF8, 1);
    acc_log.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("s6_wrap_addr", acc_log[2], 32'h0);
    lat_min = 3; lat_max = 3;
    step(0, 0, 1, 32'h800, 1);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1); chk("s6_valid_in_rst", obs_valid, 1'b0);
    step(1, 0, 0, 0, 1); chk("s6_req_in_rst", obs_req, 1'b0);
    acc_log.delete();
    step(0, 0, 0, 0, 1);
    chk("s6_post_rst_addr", obs_addr, RESET_PC);
    first_valid("s6_post_rst_pc", RESET_PC, 20);

    // Random traffic: stalls, grant gaps, variable latency, redirects, resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        lat_min = $urandom_range(1, 2); lat_max = lat_min + $urandom_range(0, 3);
      end
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0),
           $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL provide parameter XLEN, default 32: instruction and address width.
REQ-002 SHALL provide parameter DEPTH, default 4: instruction-buffer entries and the maximum number of outstanding fetches; DEPTH is a power of two and at least 2.
REQ-003 SHALL provide parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-007 SHALL have port imem_addr, output, XLEN bits: fetch address.
REQ-008 SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-009 SHALL have port imem_rvalid, input, 1 bit: response valid; responses return in request order, with latency of 1 or more cycles.
REQ-010 SHALL have port imem_rdata, input, XLEN bits: instruction word returned with the response.
REQ-011 SHALL have port pcsrc, input, 1 bit: redirect (branch taken or jump) from decode.
REQ-012 SHALL have port pcbranch, input, XLEN bits: redirect target address.
REQ-013 SHALL have port stallD, input, 1 bit: decode cannot accept an instruction this cycle.
REQ-014 SHALL have port validD, output, 1 bit: instrD and pcD hold a valid instruction.
REQ-015 SHALL have port instrD, output, XLEN bits: instruction at the buffer head.
REQ-016 SHALL have port pcD, output, XLEN bits: PC of instrD.

Function
REQ-017 SHALL hold the following state: fetch_pc, resp_pc, a FIFO of DEPTH {pc,instr} entries with a count, an outstanding counter (0..DEPTH) and a drop counter (0..DEPTH).
REQ-018 SHALL drive imem_req = !rst && !pcsrc && (count + outstanding < DEPTH), imem_addr = fetch_pc, using combinational logic from state only.
REQ-019 SHALL treat a request as accepted when imem_req && imem_gnt; on acceptance, fetch_pc advances by 4 (mod 2^XLEN) and outstanding increments.
REQ-020 SHALL hold imem_addr stable while imem_req is high and imem_gnt is low.
REQ-021 SHALL decrement outstanding on every imem_rvalid; acceptance and response in the same cycle leave outstanding unchanged.
REQ-022 SHALL discard a response when the drop counter is non-zero and decrement the drop counter.
REQ-023 SHALL otherwise push {resp_pc, imem_rdata} into the FIFO and advance resp_pc by 4.
REQ-024 SHALL have no bypass: a response received in cycle N appears on validD no earlier than cycle N+1.
REQ-025 SHALL drive validD = (count != 0); instrD and pcD show the head entry and are don't-care while validD is low.
REQ-026 SHALL pop the head when validD && !stallD; a simultaneous push and pop leaves count unchanged, and the FIFO wraps modulo DEPTH.
REQ-027 SHALL never overflow: the credit rule in REQ-018 guarantees this, and a push into a full FIFO is an assertion failure.
REQ-028 SHALL, on pcsrc: empty the FIFO (count to 0, the same-cycle pop is ignored), set fetch_pc and resp_pc to pcbranch, and set the drop counter to outstanding minus any response this cycle.
REQ-029 SHALL drop a response arriving in the same cycle as pcsrc.
REQ-030 SHALL keep imem_req low in the pcsrc cycle; fetching from pcbranch begins the next cycle.
REQ-031 SHALL, on back-to-back pcsrc, let the last redirect win; the drop counter always equals the outstanding responses that are still stale.
REQ-032 SHALL, when stallD is held, let the FIFO fill to DEPTH; requests stop once count + outstanding = DEPTH and resume on the first pop.
REQ-033 SHALL sustain full throughput with single-cycle memory: one instruction per cycle after a 2-cycle startup.

Reset
REQ-034 SHALL, on rst high at a clock edge: fetch_pc = resp_pc = RESET_PC, count = outstanding = drop = 0.
REQ-035 SHALL hold validD = 0 and imem_req = 0 while rst is high.
REQ-036 SHALL discard any response arriving during or after a mid-operation reset that belongs to a pre-reset request; the memory is reset by the same rst.
REQ-037 SHALL issue the first request, to RESET_PC, in the first cycle after rst deasserts.

Verification
REQ-038 SHALL cover this scenario: reset, then gnt always 1, 1-cycle latency, stallD = 0 -> addresses 0,4,8,...; validD rises 2 cycles after the first request; pcD sequence 0,4,8 with matching instrD.
REQ-039 SHALL cover this scenario: stallD held 20 cycles, DEPTH = 4 -> exactly 4 requests accepted, count = 4, imem_req low; stallD released -> pcD 0,4,8,12 popped one per cycle, and requests resume at address 16.
REQ-040 SHALL cover this scenario: 3 outstanding requests (0x20, 0x24, 0x28) at 3-cycle latency, then pcsrc with pcbranch = 0x100 -> all 3 responses dropped, validD stays low, next request is 0x100, and the first pcD is 0x100.
REQ-041 SHALL cover this scenario: pcsrc in the same cycle as imem_rvalid and a pop -> the response is dropped, the pop is ignored, and drop = outstanding - 1.
REQ-042 SHALL cover this scenario: imem_gnt held low for 5 cycles with imem_req high -> imem_addr stays constant and outstanding stays 0.
REQ-043 SHALL cover this scenario: fetch_pc = 0xFFFF_FFFC -> the next address wraps to 0x0000_0000; and rst asserted with 2 requests in flight -> validD stays 0 and the first post-reset pcD is RESET_PC.
